// File: rtl/radix2_div_seq_if.sv
// Handshake and data bundle for radix2_div_seq: operands in with nd, results out with valid.
interface radix2_div_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             nd;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             valid;
    logic             busy;
    logic             dbz;

    modport master (
        output nd, a, b,
        input  q, r, valid, busy, dbz
    );

    modport slave (
        input  nd, a, b,
        output q, r, valid, busy, dbz
    );
endinterface

// File: rtl/radix2_div_seq.sv
// Iterative signed restoring divider, one quotient bit per clock, truncating toward zero.
// Define DIV_EARLY_DBZ_EN to let divide-by-zero bypass the iteration and finish in one step.
module radix2_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clk,
    input logic             reset_n,
    radix2_div_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] dvd_q;   // dividend magnitude; quotient bits shift in at the bottom
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic [CntW-1:0]  cnt_q;
    logic             sign_quo_q;
    logic             sign_rem_q;
    logic             dbz_pend_q;
    logic             valid_q;
    logic             busy_q;
    logic             dbz_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   trial;

    always_comb begin
        a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
        b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;
        // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted trial.
        trial = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            q_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            dbz_pend_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.nd) begin
                        dvd_q      <= a_mag;
                        dvs_q      <= b_mag;
                        rem_q      <= '0;
                        sign_quo_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        sign_rem_q <= bus.a[WIDTH-1];
                        dbz_pend_q <= (bus.b == '0);
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
`ifdef DIV_EARLY_DBZ_EN
                        if (bus.b == '0) begin
                            rem_q   <= a_mag;
                            state_q <= StFix;
                        end else begin
                            state_q <= StCalc;
                        end
`else
                        state_q <= StCalc;
`endif
                    end
                end
                StCalc: begin
                    if (trial[WIDTH]) begin
                        rem_q <= {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
                        dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_q <= trial[WIDTH-1:0];
                        dvd_q <= {dvd_q[WIDTH-2:0], 1'b1};
                    end
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    // With a zero divisor the remainder path has reassembled |a|, so r == a.
                    q_q     <= dbz_pend_q ? '1 : (sign_quo_q ? -dvd_q : dvd_q);
                    r_q     <= sign_rem_q ? -rem_q : rem_q;
                    dbz_q   <= dbz_pend_q;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.q     = q_q;
    assign bus.r     = r_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.dbz   = dbz_q;
endmodule
